// File: rtl/life_step_engine.sv
// -----------------------------------------------------------------------------
// life_step_engine
//
// Computes one Game of Life generation per start request on a toroidal
// 2^X_BITS x 2^Y_BITS grid held in a 1-bit-wide dual-port cell RAM. The engine
// owns RAM port A; port B is left to the video scan-out.
//
// The RAM is double-buffered: the address MSB selects the bank. A generation
// reads bank src_bank and writes bank ~src_bank, then src_bank flips so the
// display follows the newest complete generation.
//
// Each row costs 6 + 4*W cycles: six PRE cycles prime a 3x3 window with the
// columns W-1 and 0, then every cell takes four RUN phases (three reads of the
// column to the right, one write of the new cell).
//
// Ports:
//   clk        system clock
//   resetn     asynchronous active-low reset
//   start      one-cycle request for a generation, sampled only in IDLE
//   busy       high while a generation is in progress
//   done       one-cycle pulse when a generation completes
//   disp_bank  bank holding the newest complete generation
//   mem_ad     port A address {bank, y, x}
//   mem_ce     port A clock enable
//   mem_wre    port A write enable
//   mem_din    port A write data
//   mem_dout   port A read data, valid the cycle after a read is issued
// -----------------------------------------------------------------------------
module life_step_engine #(
    parameter int unsigned X_BITS       = 8,
    parameter int unsigned Y_BITS       = 8,
    parameter logic [8:0]  BIRTH_MASK   = 9'b000001000,
    parameter logic [8:0]  SURVIVE_MASK = 9'b000001100
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     disp_bank,
    output logic [Y_BITS+X_BITS:0]   mem_ad,
    output logic                     mem_ce,
    output logic                     mem_wre,
    output logic                     mem_din,
    input  logic                     mem_dout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam logic [X_BITS-1:0] X_LAST = '1;
    localparam logic [Y_BITS-1:0] Y_LAST = '1;
    localparam logic [X_BITS-1:0] X_ONE  = X_BITS'(1);
    localparam logic [Y_BITS-1:0] Y_ONE  = Y_BITS'(1);

    state_t state;
    state_t state_next;

    logic [X_BITS-1:0] x;
    logic [Y_BITS-1:0] y;
    logic [2:0]        phase;
    logic              src_bank;

    // Window columns, bit 0 = row y-1, bit 1 = row y, bit 2 = row y+1.
    logic [2:0] col_l;
    logic [2:0] col_c;
    // Rows y-1 and y of the right column, captured in P1 and P2.
    logic       r_0;
    logic       r_1;

    logic [Y_BITS-1:0] y_up;
    logic [Y_BITS-1:0] y_dn;
    logic [X_BITS-1:0] x_nxt;
    logic [Y_BITS-1:0] rd_row;
    logic [X_BITS-1:0] pre_col;
    logic [2:0]        col_r;
    logic [7:0]        nbrs;
    logic [3:0]        n;
    logic              cell_next;
    logic              row_end;
    logic              grid_end;

    // Natural wrap of the counters gives the toroidal neighbourhood.
    assign y_up     = y - Y_ONE;
    assign y_dn     = y + Y_ONE;
    assign x_nxt    = x + X_ONE;
    assign row_end  = (x == X_LAST);
    assign grid_end = row_end && (y == Y_LAST);

    assign busy      = (state != IDLE);
    assign disp_bank = src_bank;

    // Both PRE and RUN issue their reads in the order y-1, y, y+1.
    always_comb begin
        rd_row = y;
        case (phase)
            3'd0, 3'd3: rd_row = y_up;
            3'd2, 3'd5: rd_row = y_dn;
            default:    rd_row = y;
        endcase
    end

    // PRE reads column W-1 in phases 0..2 and column 0 in phases 3..5.
    assign pre_col = (phase < 3'd3) ? X_LAST : '0;

    // The y+1 datum of the right column arrives on mem_dout during P3 and is
    // used directly rather than waiting another cycle to register it.
    assign col_r = {mem_dout, r_1, r_0};
    assign nbrs  = {col_l, col_c[2], col_c[0], col_r};

    always_comb begin
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, nbrs[i]};
        end
    end

    assign cell_next = col_c[1] ? SURVIVE_MASK[n] : BIRTH_MASK[n];

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and RAM port A controls.
    always_comb begin
        // NOTE: every output of this block gets a default before the case so no
        // path through it leaves a value unassigned, which would infer a latch.
        state_next = state;
        mem_ce     = 1'b0;
        mem_wre    = 1'b0;
        mem_din    = 1'b0;
        mem_ad     = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = PRE;
                end
            end
            PRE: begin
                mem_ce = 1'b1;
                mem_ad = {src_bank, rd_row, pre_col};
                if (phase == 3'd5) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                mem_ce = 1'b1;
                if (phase == 3'd3) begin
                    mem_wre = 1'b1;
                    mem_ad  = {~src_bank, y, x};
                    mem_din = cell_next;
                    if (grid_end) begin
                        state_next = IDLE;
                    end else if (row_end) begin
                        state_next = PRE;
                    end
                end else begin
                    mem_ad = {src_bank, rd_row, x_nxt};
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Counters, window and bank bookkeeping.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x        <= '0;
            y        <= '0;
            phase    <= 3'd0;
            src_bank <= 1'b0;
            done     <= 1'b0;
            col_l    <= 3'b000;
            col_c    <= 3'b000;
            r_0      <= 1'b0;
            r_1      <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // register in this block sees the pre-edge values of the others.
            done <= 1'b0;
            case (state)
                IDLE: begin
                    x     <= '0;
                    y     <= '0;
                    phase <= 3'd0;
                end
                PRE: begin
                    phase <= (phase == 3'd5) ? 3'd0 : phase + 3'd1;
                    // Each datum lands one cycle after its read was issued.
                    case (phase)
                        3'd1: col_c[0] <= mem_dout;
                        3'd2: col_c[1] <= mem_dout;
                        // Last column W-1 datum: the whole column moves to L
                        // while column 0 starts filling C.
                        3'd3: col_l    <= {mem_dout, col_c[1:0]};
                        3'd4: col_c[0] <= mem_dout;
                        3'd5: col_c[1] <= mem_dout;
                        default: ;
                    endcase
                end
                RUN: begin
                    phase <= (phase == 3'd3) ? 3'd0 : phase + 3'd1;
                    case (phase)
                        // Only the first cell of a row follows PRE, whose last
                        // read (column 0, row y+1) is still outstanding.
                        3'd0: begin
                            if (x == '0) begin
                                col_c[2] <= mem_dout;
                            end
                        end
                        3'd1: r_0 <= mem_dout;
                        3'd2: r_1 <= mem_dout;
                        3'd3: begin
                            col_l <= col_c;
                            col_c <= col_r;
                            x     <= x_nxt;
                            if (row_end) begin
                                y <= y_dn;
                                if (y == Y_LAST) begin
                                    src_bank <= ~src_bank;
                                    done     <= 1'b1;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_life_step_engine.sv
// -----------------------------------------------------------------------------
// tb_life_step_engine
//
// Drives life_step_engine on a 16x16 torus with a behavioural dual-bank cell
// RAM. A table of seed patterns with hand-derived results is applied first,
// followed by handshake sequences, a random seed tracked by a reference model
// over several generations, and an asynchronous reset in the middle of a run.
// -----------------------------------------------------------------------------
module tb_life_step_engine;

    localparam int XB      = 4;
    localparam int YB      = 4;
    localparam int W       = 1 << XB;
    localparam int H       = 1 << YB;
    localparam int N       = W * H;
    localparam int AW      = 1 + XB + YB;
    localparam int GEN_CYC = H * (6 + 4 * W);

    logic          clk = 1'b0;
    logic          resetn;
    logic          start;
    logic          busy;
    logic          done;
    logic          disp_bank;
    logic [AW-1:0] mem_ad;
    logic          mem_ce;
    logic          mem_wre;
    logic          mem_din;
    logic          ram_dout;

    logic ram [0:2*N-1];

    int  checks = 0;
    int  errors = 0;
    int  wr_count = 0;
    int  bad_wr = 0;
    bit  exp_dest = 1'b1;
    bit  cur_bank = 1'b0;
    bit  model [0:N-1];

    always #5 clk = ~clk;

    life_step_engine #(
        .X_BITS       (XB),
        .Y_BITS       (YB),
        .BIRTH_MASK   (9'b000001000),
        .SURVIVE_MASK (9'b000001100)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .disp_bank (disp_bank),
        .mem_ad    (mem_ad),
        .mem_ce    (mem_ce),
        .mem_wre   (mem_wre),
        .mem_din   (mem_din),
        .mem_dout  (ram_dout)
    );

    // Synchronous single-port view of the cell RAM (port A).
    always @(posedge clk) begin
        if (mem_ce) begin
            if (mem_wre) ram[mem_ad] <= mem_din;
            else         ram_dout    <= ram[mem_ad];
        end
    end

    // Write monitor: counts writes and flags any that land outside the
    // destination bank.
    always @(posedge clk) begin
        if (mem_ce === 1'b1 && mem_wre === 1'b1) begin
            wr_count++;
            if (mem_ad[AW-1] !== exp_dest) bad_wr++;
        end
    end

    // Seed table: cells packed as 8'hXY (x high nibble, y low nibble),
    // element 0 first.
    typedef struct packed {
        logic [2:0]      nseed;
        logic [4:0][7:0] seed;
        logic [2:0]      gens;
        logic [2:0]      nexp;
        logic [4:0][7:0] exp_cells;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic int base_of(input bit bank);
        return bank ? N : 0;
    endfunction

    task automatic load_cells(input logic [4:0][7:0] cells, input int n);
        for (int a = 0; a < N; a++) begin
            model[a] = 1'b0;
            ram[base_of(cur_bank) + a]  = 1'b0;
            ram[base_of(!cur_bank) + a] = 1'b1;
        end
        for (int i = 0; i < n; i++) begin
            int cx;
            int cy;
            cx = int'(cells[i][7:4]);
            cy = int'(cells[i][3:0]);
            model[cy * W + cx] = 1'b1;
            ram[base_of(cur_bank) + cy * W + cx] = 1'b1;
        end
    endtask

    task automatic load_random();
        for (int a = 0; a < N; a++) begin
            model[a] = 1'($urandom_range(0, 1));
            ram[base_of(cur_bank) + a]  = model[a];
            ram[base_of(!cur_bank) + a] = 1'b1;
        end
    endtask

    // Reference B3/S23 step on the torus.
    task automatic step_model();
        bit nxt [0:N-1];
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                int cnt;
                cnt = 0;
                for (int dy = -1; dy <= 1; dy++) begin
                    for (int dx = -1; dx <= 1; dx++) begin
                        if (dx != 0 || dy != 0) begin
                            if (model[((y + dy + H) % H) * W + ((x + dx + W) % W)]) cnt++;
                        end
                    end
                end
                if (model[y * W + x]) nxt[y * W + x] = (cnt == 2 || cnt == 3);
                else                  nxt[y * W + x] = (cnt == 3);
            end
        end
        for (int a = 0; a < N; a++) model[a] = nxt[a];
    endtask

    function automatic int model_diff();
        int d;
        d = 0;
        for (int a = 0; a < N; a++) begin
            if (ram[base_of(cur_bank) + a] !== model[a]) d++;
        end
        return d;
    endfunction

    function automatic int hand_diff(input logic [4:0][7:0] cells, input int n);
        bit e [0:N-1];
        int d;
        for (int a = 0; a < N; a++) e[a] = 1'b0;
        for (int i = 0; i < n; i++) begin
            e[int'(cells[i][3:0]) * W + int'(cells[i][7:4])] = 1'b1;
        end
        d = 0;
        for (int a = 0; a < N; a++) begin
            if (ram[base_of(cur_bank) + a] !== e[a]) d++;
        end
        return d;
    endfunction

    // Runs one generation. Called at a negedge with the DUT idle (or, when
    // chained_in is set, one cycle into a generation started in the previous
    // done cycle). Returns at a negedge one cycle after done.
    task automatic run_gen(input string tag, input int hold, input int mid_at,
                           input bit chained_in, input bit chain_next);
        bit snap [0:N-1];
        int cyc;
        int d;
        for (int a = 0; a < N; a++) snap[a] = ram[base_of(cur_bank) + a];
        exp_dest = !cur_bank;
        wr_count = 0;
        bad_wr   = 0;
        if (!chained_in) begin
            start = 1'b1;
            @(negedge clk);
        end
        cyc = 0;
        while (busy === 1'b1 && cyc <= GEN_CYC + 50) begin
            cyc++;
            start = (cyc < hold) || (cyc == mid_at);
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, " busy cycles"}, cyc, GEN_CYC);
        check({tag, " done"}, done, 1);
        check({tag, " disp_bank"}, disp_bank, !cur_bank);
        cur_bank = !cur_bank;
        check({tag, " writes"}, wr_count, N);
        check({tag, " stray writes"}, bad_wr, 0);
        d = 0;
        for (int a = 0; a < N; a++) begin
            if (ram[base_of(!cur_bank) + a] !== snap[a]) d++;
        end
        check({tag, " source bank changed"}, d, 0);
        step_model();
        check({tag, " grid vs model"}, model_diff(), 0);
        if (chain_next) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, " done width"}, done, 0);
        if (!chain_next) check({tag, " no restart"}, busy, 0);
    endtask

    initial begin
        vecs[0] = '{nseed: 3'd3, seed: {8'h00, 8'h00, 8'hAB, 8'hAA, 8'hA9},
                    gens: 3'd1, nexp: 3'd3, exp_cells: {8'h00, 8'h00, 8'hBA, 8'hAA, 8'h9A}};
        vecs[1] = '{nseed: 3'd4, seed: {8'h00, 8'h11, 8'h10, 8'h01, 8'h00},
                    gens: 3'd1, nexp: 3'd4, exp_cells: {8'h00, 8'h11, 8'h10, 8'h01, 8'h00}};
        vecs[2] = '{nseed: 3'd4, seed: {8'h00, 8'h00, 8'hF0, 8'h0F, 8'hFF},
                    gens: 3'd1, nexp: 3'd4, exp_cells: {8'h00, 8'h00, 8'hF0, 8'h0F, 8'hFF}};
        vecs[3] = '{nseed: 3'd1, seed: {8'h00, 8'h00, 8'h00, 8'h00, 8'h55},
                    gens: 3'd1, nexp: 3'd0, exp_cells: '0};
        vecs[4] = '{nseed: 3'd3, seed: {8'h00, 8'h00, 8'h14, 8'h04, 8'hF4},
                    gens: 3'd1, nexp: 3'd3, exp_cells: {8'h00, 8'h00, 8'h05, 8'h04, 8'h03}};
        vecs[5] = '{nseed: 3'd5, seed: {8'h00, 8'hF0, 8'hE0, 8'h0F, 8'hFE},
                    gens: 3'd4, nexp: 3'd5, exp_cells: {8'h11, 8'h01, 8'hF1, 8'h10, 8'h0F}};
        vecs[6] = '{nseed: 3'd3, seed: {8'h00, 8'h00, 8'hAB, 8'hAA, 8'hA9},
                    gens: 3'd2, nexp: 3'd3, exp_cells: {8'h00, 8'h00, 8'hAB, 8'hAA, 8'hA9}};

        resetn = 1'b0;
        start  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset disp_bank", disp_bank, 0);
        check("reset mem_ce", mem_ce, 0);
        check("reset mem_wre", mem_wre, 0);
        check("reset mem_din", mem_din, 0);
        check("reset mem_ad", mem_ad, 0);
        resetn = 1'b1;
        @(negedge clk);

        // Directed patterns with hand-derived results.
        for (int i = 0; i < NV; i++) begin
            load_cells(vecs[i].seed, int'(vecs[i].nseed));
            for (int g = 0; g < int'(vecs[i].gens); g++) begin
                run_gen($sformatf("v%0d g%0d", i, g), 1, 0, 1'b0, 1'b0);
            end
            check($sformatf("v%0d hand cells", i),
                  hand_diff(vecs[i].exp_cells, int'(vecs[i].nexp)), 0);
        end

        // Handshake: long start, mid-run start, start in the done cycle.
        load_random();
        run_gen("hold10", 10, 0, 1'b0, 1'b0);
        run_gen("mid pulse", 1, 500, 1'b0, 1'b0);
        run_gen("chain a", 1, 0, 1'b0, 1'b1);
        run_gen("chain b", 1, 0, 1'b1, 1'b0);

        // Random seed tracked over several generations.
        load_random();
        for (int g = 0; g < 5; g++) run_gen($sformatf("rand g%0d", g), 1, 0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of RUN with bank 1 displayed.
        if (!cur_bank) run_gen("pre-reset", 1, 0, 1'b0, 1'b0);
        check("pre-reset disp_bank", disp_bank, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (300) @(negedge clk);
        check("mid-run busy", busy, 1);
        #2 resetn = 1'b0;
        #1;
        check("async reset busy", busy, 0);
        check("async reset mem_ce", mem_ce, 0);
        check("async reset disp_bank", disp_bank, 0);
        check("async reset done", done, 0);
        @(negedge clk);
        resetn = 1'b1;
        cur_bank = 1'b0;
        @(negedge clk);
        load_random();
        run_gen("after reset", 1, 0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
